// File: rtl/snake_direction_ctrl_if.sv
// rtl/snake_direction_ctrl_if.sv - button/tick inputs and heading/queue status of the direction controller
interface snake_direction_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       tick;
    logic [1:0] dir;
    logic [3:0] queue_count;
    logic       turned;
    logic       dropped;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, tick,
        input  dir, queue_count, turned, dropped
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, tick,
        output dir, queue_count, turned, dropped
    );
endinterface

// File: rtl/snake_direction_ctrl.sv
// rtl/snake_direction_ctrl.sv - debounced button turn queue feeding the snake heading on each tick
module snake_direction_ctrl #(
    parameter int         DEPTH           = 4,
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter logic [1:0] INIT_DIR        = 2'b11
) (
    input  logic                  clk,
    input  logic                  reset,
    snake_direction_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Bit index equals the heading encoding: 0 up, 1 down, 2 left, 3 right.
    logic [3:0]    raw;
    logic [3:0]    sync1, sync2, deb, deb_prev;
    logic [CW-1:0] cnt [4];
    logic [3:0]    press;

    assign raw   = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
    assign press = deb & ~deb_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 4'hF;
            sync2    <= 4'hF;
            deb      <= 4'hF;
            deb_prev <= 4'hF;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < 4; i++) begin
                if (cnt[i] == CW'(DEBOUNCE_CYCLES)) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    logic [1:0]    mem [DEPTH];
    logic [PW-1:0] head;
    logic [3:0]    count;
    logic [1:0]    dir;
    logic          turned, dropped;

    logic [4:0]    tail_sum;
    logic [PW-1:0] tail_idx, newest_idx, head_next;
    logic [1:0]    cand, ref_dir;
    logic          cand_valid, multi, full, pop, reject, push;

    assign tail_sum   = {{(5-PW){1'b0}}, head} + {1'b0, count};
    assign tail_idx   = (tail_sum >= 5'(DEPTH)) ? PW'(tail_sum - 5'(DEPTH)) : PW'(tail_sum);
    assign newest_idx = (tail_idx == '0) ? PW'(DEPTH - 1) : tail_idx - PW'(1);
    assign head_next  = (head == PW'(DEPTH - 1)) ? '0 : head + PW'(1);

    always_comb begin
        cand       = 2'b11;
        cand_valid = |press;
        multi      = (press & (press - 4'd1)) != 4'd0;
        if (press[0])      cand = 2'b00;
        else if (press[1]) cand = 2'b01;
        else if (press[2]) cand = 2'b10;
        full    = count == 4'(DEPTH);
        pop     = bus.tick && (count != 4'd0);
        ref_dir = (count != 4'd0) ? mem[newest_idx] : dir;
        // A full queue still accepts when the same cycle's tick frees the head slot.
        reject  = cand_valid && ((cand == ref_dir) || (cand == (ref_dir ^ 2'b01)) || (full && !pop));
        push    = cand_valid && !reject;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir     <= INIT_DIR;
            head    <= '0;
            count   <= 4'd0;
            turned  <= 1'b0;
            dropped <= 1'b0;
        end else begin
            turned  <= pop;
            dropped <= multi || reject;
            if (pop) begin
                dir  <= mem[head];
                head <= head_next;
            end
            if (push) mem[tail_idx] <= cand;
            if (push && !pop)      count <= count + 4'd1;
            else if (pop && !push) count <= count - 4'd1;
        end
    end

    assign bus.dir         = dir;
    assign bus.queue_count = count;
    assign bus.turned      = turned;
    assign bus.dropped     = dropped;
endmodule

// File: tb/tb_snake_direction_ctrl.sv
// tb/tb_snake_direction_ctrl.sv - scoreboard bench for snake_direction_ctrl at depth 4 and depth 2
module tb_snake_direction_ctrl;
    localparam int NO_EVENT = 'hFFF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b1;
    logic tick_a = 1'b0, tick_b = 1'b0;
    bit   mon_a = 1'b0, mon_b = 1'b0;

    int checks = 0;
    int errors = 0;
    int exp_a[$];
    int exp_b[$];

    always #5 clk = ~clk;

    snake_direction_ctrl_if a_if ();
    snake_direction_ctrl_if b_if ();

    assign a_if.btn_up = btn_up;  assign a_if.btn_down = btn_down;
    assign a_if.btn_left = btn_left; assign a_if.btn_right = btn_right;
    assign a_if.tick = tick_a;
    assign b_if.btn_up = btn_up;  assign b_if.btn_down = btn_down;
    assign b_if.btn_left = btn_left; assign b_if.btn_right = btn_right;
    assign b_if.tick = tick_b;

    snake_direction_ctrl #(.DEPTH(4), .DEBOUNCE_CYCLES(4), .INIT_DIR(2'b11)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if));
    snake_direction_ctrl #(.DEPTH(2), .DEBOUNCE_CYCLES(4), .INIT_DIR(2'b11)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Event word: {dir[1:0], queue_count[3:0], turned, dropped}
    function automatic int ev(input logic [1:0] d, input logic [3:0] c, input bit t, input bit dr);
        return int'({d, c, t, dr});
    endfunction

    logic [1:0] pdir_a = 2'b11, pdir_b = 2'b11;
    logic [3:0] pcnt_a = 4'd0, pcnt_b = 4'd0;
    int cur_a, cur_b;

    always @(negedge clk) begin
        cur_a = ev(a_if.dir, a_if.queue_count, a_if.turned, a_if.dropped);
        if (mon_a && (a_if.turned || a_if.dropped || a_if.dir != pdir_a || a_if.queue_count != pcnt_a)) begin
            if (exp_a.size() == 0) check("unexpected_a", cur_a, NO_EVENT);
            else check("event_a", cur_a, exp_a.pop_front());
        end
        pdir_a = a_if.dir;
        pcnt_a = a_if.queue_count;
    end

    always @(negedge clk) begin
        cur_b = ev(b_if.dir, b_if.queue_count, b_if.turned, b_if.dropped);
        if (mon_b && (b_if.turned || b_if.dropped || b_if.dir != pdir_b || b_if.queue_count != pcnt_b)) begin
            if (exp_b.size() == 0) check("unexpected_b", cur_b, NO_EVENT);
            else check("event_b", cur_b, exp_b.pop_front());
        end
        pdir_b = b_if.dir;
        pcnt_b = b_if.queue_count;
    end

    task automatic set_tick(input bit sel, input logic v);
        if (sel) tick_b = v;
        else     tick_a = v;
    endtask

    // m = {right, left, down, up}; with_tick lands the tick on the push edge (edge 3+DEBOUNCE_CYCLES).
    task automatic press(input logic [3:0] m, input bit sel, input bit with_tick);
        @(posedge clk); #1;
        {btn_right, btn_left, btn_down, btn_up} = m;
        repeat (7) @(posedge clk);
        if (with_tick) begin
            #1 set_tick(sel, 1'b1);
            @(posedge clk); #1 set_tick(sel, 1'b0);
        end else begin
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1 {btn_right, btn_left, btn_down, btn_up} = 4'b0000;
        repeat (10) @(posedge clk);
    endtask

    task automatic do_tick(input bit sel);
        @(posedge clk); #1 set_tick(sel, 1'b1);
        @(posedge clk); #1 set_tick(sel, 1'b0);
        repeat (3) @(posedge clk);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("rst_dir", a_if.dir, 2'b11);
        check("rst_count", a_if.queue_count, 0);
        check("rst_turned", a_if.turned, 0);
        check("rst_dropped", a_if.dropped, 0);
        mon_a = 1'b1;
        reset = 1'b0;

        // Right held through reset must never produce a press.
        repeat (40) @(posedge clk);
        #1;
        check("held_dir", a_if.dir, 2'b11);
        check("held_count", a_if.queue_count, 0);
        btn_right = 1'b0;
        repeat (12) @(posedge clk);

        exp_a.push_back(ev(2'b11, 4'd1, 1'b0, 1'b0));
        press(4'b0001, 1'b0, 1'b0);
        exp_a.push_back(ev(2'b00, 4'd0, 1'b1, 1'b0));
        do_tick(1'b0);

        exp_a.push_back(ev(2'b11, 4'd0, 1'b0, 1'b0));
        reset_pulse();
        repeat (4) @(posedge clk);
        exp_a.push_back(ev(2'b11, 4'd1, 1'b0, 1'b0));
        press(4'b0001, 1'b0, 1'b0);
        exp_a.push_back(ev(2'b11, 4'd2, 1'b0, 1'b0));
        press(4'b0100, 1'b0, 1'b0);
        exp_a.push_back(ev(2'b11, 4'd3, 1'b0, 1'b0));
        press(4'b0010, 1'b0, 1'b0);
        exp_a.push_back(ev(2'b00, 4'd2, 1'b1, 1'b0));
        do_tick(1'b0);
        exp_a.push_back(ev(2'b10, 4'd1, 1'b1, 1'b0));
        do_tick(1'b0);
        exp_a.push_back(ev(2'b01, 4'd0, 1'b1, 1'b0));
        do_tick(1'b0);

        exp_a.push_back(ev(2'b01, 4'd0, 1'b0, 1'b1));
        press(4'b0001, 1'b0, 1'b0);

        exp_a.push_back(ev(2'b01, 4'd1, 1'b0, 1'b0));
        press(4'b0100, 1'b0, 1'b0);
        exp_a.push_back(ev(2'b01, 4'd1, 1'b0, 1'b1));
        press(4'b0100, 1'b0, 1'b0);

        exp_a.push_back(ev(2'b01, 4'd2, 1'b0, 1'b0));
        press(4'b0001, 1'b0, 1'b0);
        exp_a.push_back(ev(2'b01, 4'd3, 1'b0, 1'b0));
        press(4'b1000, 1'b0, 1'b0);
        exp_a.push_back(ev(2'b11, 4'd0, 1'b0, 1'b0));
        reset_pulse();
        #1;
        check("midrst_dir", a_if.dir, 2'b11);
        check("midrst_count", a_if.queue_count, 0);

        // Short glitch, then ticks on an empty queue: no events at all.
        @(posedge clk); #1 btn_up = 1'b1;
        repeat (2) @(posedge clk);
        #1 btn_up = 1'b0;
        repeat (12) @(posedge clk);
        do_tick(1'b0);
        do_tick(1'b0);
        #1;
        check("post_dir", a_if.dir, 2'b11);

        mon_a = 1'b0;
        reset_pulse();
        repeat (4) @(posedge clk);
        mon_b = 1'b1;

        exp_b.push_back(ev(2'b11, 4'd1, 1'b0, 1'b0));
        press(4'b0001, 1'b1, 1'b0);
        exp_b.push_back(ev(2'b11, 4'd2, 1'b0, 1'b0));
        press(4'b0100, 1'b1, 1'b0);
        exp_b.push_back(ev(2'b11, 4'd2, 1'b0, 1'b1));
        press(4'b0001, 1'b1, 1'b0);
        exp_b.push_back(ev(2'b00, 4'd2, 1'b1, 1'b0));
        press(4'b0001, 1'b1, 1'b1);
        exp_b.push_back(ev(2'b10, 4'd1, 1'b1, 1'b0));
        do_tick(1'b1);
        exp_b.push_back(ev(2'b00, 4'd0, 1'b1, 1'b0));
        do_tick(1'b1);
        exp_b.push_back(ev(2'b00, 4'd1, 1'b0, 1'b0));
        press(4'b0100, 1'b1, 1'b0);
        exp_b.push_back(ev(2'b10, 4'd0, 1'b1, 1'b0));
        do_tick(1'b1);
        exp_b.push_back(ev(2'b10, 4'd1, 1'b0, 1'b1));
        press(4'b0101, 1'b1, 1'b0);
        exp_b.push_back(ev(2'b00, 4'd0, 1'b1, 1'b0));
        do_tick(1'b1);

        repeat (5) @(posedge clk);
        check("pending_a", exp_a.size(), 0);
        check("pending_b", exp_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/snake_direction_ctrl.md
# snake_direction_ctrl

Turns the four raw direction buttons into an ordered queue of legal snake heading changes. Each change is applied once per game-step strobe `tick`. The block synchronizes, debounces and edge-detects each button, then arbitrates simultaneous presses. It rejects reversals and duplicates and buffers up to `DEPTH` turns, so that fast key sequences between steps are kept. It sits between the board push-buttons and the snake movement logic. It owns the authoritative current heading `dir`.

## Interface
- `DEPTH`, 4: turn-queue capacity; legal values 1..8.
- `DEBOUNCE_CYCLES`, 16: number of consecutive disagreeing samples needed to change a debounced level; must be at least 1.
- `INIT_DIR`, 2'b11: heading after reset.
- `clk` in 1: single clock. All state changes on its posedge.
- `reset` in 1: synchronous, active-high.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: raw asynchronous buttons, active-high.
- `tick` in 1: one-cycle game-step strobe.
- `dir` out 2: current heading. Encoding: 00 up, 01 down, 10 left, 11 right. Opposite of d is d ^ 2'b01.
- `queue_count` out 4: number of queued turns, 0..DEPTH.
- `turned` out 1: one-cycle pulse when `dir` changed on a tick.
- `dropped` out 1: one-cycle pulse when a press was rejected.

## Operation
- Per button: a 2-flop synchronizer feeds a debouncer.
  - Debouncer counter: reset to 0 whenever the synchronized sample equals the debounced level; otherwise increments.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
- Press detect: `press = deb & ~deb_prev`.
  - `deb` and `deb_prev` reset to 1, so a button held through reset never produces a press.
- Same-cycle presses: priority up > down > left > right. Exactly one candidate survives. Every losing press pulses `dropped`; one pulse covers any number of losers.
- Reference heading `ref` = newest queue entry if `queue_count > 0`, else `dir`. Both are sampled before this cycle's pop.
- A candidate is rejected, pulsing `dropped`, if any of these holds:
  - it equals `ref`;
  - it equals `ref ^ 2'b01`;
  - the queue is full and `tick` is not popping this cycle.
- Otherwise the candidate is pushed at the tail.
- On `tick` with a non-empty queue:
  - the head is popped into `dir`;
  - `turned` = 1 next cycle;
  - `queue_count` decrements, unless a push occurs in the same cycle, in which case it is unchanged.
- On `tick` with an empty queue: `dir` is held and `turned` = 0.
- No bypass: a press pushed in the same cycle as a `tick` into an empty queue is applied on the next `tick`, not this one.
- Queue: circular buffer with a head pointer (`DEPTH`-wrap) and a count. Pointers wrap from `DEPTH-1` to 0.
- Reset, including mid-operation: `dir = INIT_DIR` and the queue is emptied (pending turns discarded).

## Timing
- Reset values:
  - `dir = INIT_DIR`, `queue_count = 0`, `turned = 0`, `dropped = 0`;
  - synchronizer flops = 1, `deb = 1`, `deb_prev = 1`, debounce counters = 0.
- Clean button rising edge, first sampled high at edge 0:
  - debounced level high after edge 2+`DEBOUNCE_CYCLES`;
  - push and `queue_count` update (or `dropped` = 1) after edge 3+`DEBOUNCE_CYCLES`.
  - With the default, this is 19 edges.
- `tick` sampled high at edge t: `dir`, `turned` and `queue_count` update after edge t. `turned` lasts exactly one cycle.
- `dropped` and `turned` are registered outputs, high for exactly one cycle per event. Both may be high in the same cycle.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no press.
- A button held high generates exactly one press. Release is debounced the same way and produces no event.

## Test plan
- Reset with `btn_right` held and `INIT_DIR` = 11, `DEBOUNCE_CYCLES` = 4 -> 40 cycles later: `dir` = 11, `queue_count` = 0, `dropped` never asserted.
- Up pressed cleanly from `dir` = 11, then `tick` at cycle 20 -> `queue_count` = 1 at cycle 7. After the tick: `dir` = 00 and `turned` pulses once.
- Press sequence up, left, down from `dir` = 11 with no tick, then 3 ticks -> all accepted, `queue_count` = 3. The ticks give `dir` = 00, 10, 01 in order.
- Left pressed while `dir` = 11 and the queue is empty -> reversal rejected: `dropped` pulses once, `queue_count` stays 0.
- Same press twice in a row -> duplicate rejected: second press gives `dropped` = 1, count unchanged.
- `DEPTH` = 2 with alternating up/left presses:
  - 3rd push while full -> `dropped` = 1;
  - press coinciding with a `tick` while full -> accepted, `queue_count` stays 2;
  - up and left pressed in the same cycle -> up queued, `dropped` = 1.
- `reset` asserted for one cycle with `queue_count` = 3 -> next cycle: `queue_count` = 0 and `dir` = `INIT_DIR`; subsequent ticks leave `dir` unchanged.
